// File: rtl/fp_result_collector.sv
// Return-path result collector for the FP co-processor. It buffers completions from each
// execution unit and hands them back to the CPU in issue order.
module fp_result_collector #(
  parameter int unsigned TAG_DEPTH  = 8,
  parameter int unsigned UNIT_DEPTH = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         tag_push,
  input  logic [2:0]                   tag_in,
  output logic                         tag_full,
  input  logic                         add_done,
  input  logic [31:0]                  add_result,
  input  logic                         add_overflow,
  input  logic                         mul_done,
  input  logic [31:0]                  mul_result,
  input  logic                         mul_overflow,
  input  logic                         sincos_done,
  input  logic [31:0]                  sine_result,
  input  logic [31:0]                  cosine_result,
  input  logic                         cpu_pop,
  output logic [31:0]                  result,
  output logic                         done,
  output logic                         overflow,
  output logic [$clog2(TAG_DEPTH):0]   pending,
  output logic                         err
);

  localparam int unsigned TW  = $clog2(TAG_DEPTH);
  localparam int unsigned TCW = TW + 1;
  localparam int unsigned UW  = (UNIT_DEPTH > 1) ? $clog2(UNIT_DEPTH) : 1;
  localparam int unsigned UCW = UW + 1;
  localparam logic [TCW-1:0] TagFull  = TCW'(TAG_DEPTH);
  localparam logic [UCW-1:0] UnitFull = UCW'(UNIT_DEPTH);
  localparam logic [UW-1:0]  UnitLast = UW'(UNIT_DEPTH - 1);

  // Tag FIFO
  logic [2:0]     tag_mem [TAG_DEPTH];
  logic [TW-1:0]  tag_head_q, tag_tail_q;
  logic [TCW-1:0] tag_cnt_q;

  // Unit buffers: index 0 add/sub, 1 mul, 2 trig. Entry is {hi, lo}: {ovf, result} or {sin, cos}.
  logic [63:0]    ubuf [3][UNIT_DEPTH];
  logic [UW-1:0]  u_rd_q [3];
  logic [UW-1:0]  u_wr_q [3];
  logic [UCW-1:0] u_cnt_q [3];

  logic [31:0]    result_q;
  logic           done_q, overflow_q, err_q;
  logic [TCW-1:0] pending_q;

  logic [2:0]     unit_done, wr_ok, rd_ok;
  logic [63:0]    unit_data [3];
  logic [2:0]     head_tag;
  logic [1:0]     head_unit;
  logic           head_ready;
  logic [63:0]    head_entry;
  logic           load, push_ok, push_err, buf_err, pop_ok;
  logic [31:0]    load_result;
  logic           load_ovf;

  function automatic logic [UW-1:0] unit_next(input logic [UW-1:0] p);
    return (p == UnitLast) ? '0 : p + 1'b1;
  endfunction

  assign unit_done = {sincos_done, mul_done, add_done};
  assign tag_full  = (tag_cnt_q == TagFull);

  always_comb begin
    unit_data[0] = {31'b0, add_overflow, add_result};
    unit_data[1] = {31'b0, mul_overflow, mul_result};
    unit_data[2] = {sine_result, cosine_result};
  end

  always_comb begin
    head_tag = tag_mem[tag_head_q];
    case (head_tag)
      3'd0, 3'd1: head_unit = 2'd0;
      3'd2:       head_unit = 2'd1;
      default:    head_unit = 2'd2;
    endcase
    head_ready = 1'b0;
    head_entry = '0;
    for (int u = 0; u < 3; u++) begin
      if (head_unit == 2'(u)) begin
        head_ready = (u_cnt_q[u] != '0);
        head_entry = ubuf[u][u_rd_q[u]];
      end
    end
  end

  always_comb begin
    load     = (tag_cnt_q != '0) && head_ready && (!done_q || cpu_pop);
    push_ok  = tag_push && (tag_in <= 3'd4) && !tag_full;
    push_err = tag_push && !push_ok;
    pop_ok   = cpu_pop && done_q;
    for (int u = 0; u < 3; u++) begin
      wr_ok[u] = unit_done[u] && (u_cnt_q[u] != UnitFull);
      rd_ok[u] = load && (head_unit == 2'(u));
    end
    buf_err = |(unit_done & ~wr_ok);
    // Trig tag 011 selects sine, 100 selects cosine; trig never reports overflow.
    if (head_unit == 2'd2) begin
      load_result = (head_tag == 3'd3) ? head_entry[63:32] : head_entry[31:0];
      load_ovf    = 1'b0;
    end else begin
      load_result = head_entry[31:0];
      load_ovf    = head_entry[32];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tag_head_q <= '0;
      tag_tail_q <= '0;
      tag_cnt_q  <= '0;
      for (int u = 0; u < 3; u++) begin
        u_rd_q[u]  <= '0;
        u_wr_q[u]  <= '0;
        u_cnt_q[u] <= '0;
      end
      result_q   <= '0;
      done_q     <= 1'b0;
      overflow_q <= 1'b0;
      err_q      <= 1'b0;
      pending_q  <= '0;
    end else begin
      if (push_ok) begin
        tag_mem[tag_tail_q] <= tag_in;
        tag_tail_q          <= tag_tail_q + 1'b1;
      end
      if (load) tag_head_q <= tag_head_q + 1'b1;
      tag_cnt_q <= tag_cnt_q + TCW'(push_ok) - TCW'(load);

      for (int u = 0; u < 3; u++) begin
        if (wr_ok[u]) begin
          ubuf[u][u_wr_q[u]] <= unit_data[u];
          u_wr_q[u]          <= unit_next(u_wr_q[u]);
        end
        if (rd_ok[u]) u_rd_q[u] <= unit_next(u_rd_q[u]);
        u_cnt_q[u] <= u_cnt_q[u] + UCW'(wr_ok[u]) - UCW'(rd_ok[u]);
      end

      if (load) begin
        result_q   <= load_result;
        overflow_q <= load_ovf;
        done_q     <= 1'b1;
      end else if (pop_ok) begin
        done_q <= 1'b0;
      end

      if (push_err || buf_err) err_q <= 1'b1;
      pending_q <= pending_q + TCW'(push_ok) - TCW'(pop_ok);
    end
  end

  assign result   = result_q;
  assign done     = done_q;
  assign overflow = overflow_q;
  assign pending  = pending_q;
  assign err      = err_q;

endmodule
